// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - pipeline-to-CP0 exception, MTC0/MFC0 and redirect signal bundle
interface cp0_exception_unit_if;
  logic [8:0]  MEM_ExceptType;
  logic [31:0] MEM_PC;
  logic [31:0] MEM_ALUOut;
  logic        MEM_IsDelaySlot;
  logic [5:0]  Ext_Int;
  logic        CP0_Wr;
  logic [4:0]  CP0_WrAddr;
  logic [31:0] CP0_WrData;
  logic [4:0]  CP0_RdAddr;
  logic [31:0] CP0_RdData;
  logic        Int_Pending;
  logic        Exc_Flush;
  logic [31:0] Exc_Target;

  modport master (
    output MEM_ExceptType, MEM_PC, MEM_ALUOut, MEM_IsDelaySlot, Ext_Int,
           CP0_Wr, CP0_WrAddr, CP0_WrData, CP0_RdAddr,
    input  CP0_RdData, Int_Pending, Exc_Flush, Exc_Target
  );

  modport slave (
    input  MEM_ExceptType, MEM_PC, MEM_ALUOut, MEM_IsDelaySlot, Ext_Int,
           CP0_Wr, CP0_WrAddr, CP0_WrData, CP0_RdAddr,
    output CP0_RdData, Int_Pending, Exc_Flush, Exc_Target
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 exception prioritiser, register file, flush/redirect and Count/Compare timer
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_exception_unit_if.slave   bus
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef enum logic [3:0] {
    EXC_NONE,
    EXC_INT,
    EXC_ADEL_IF,
    EXC_RI,
    EXC_OV,
    EXC_SYS,
    EXC_BP,
    EXC_ERET,
    EXC_ADES,
    EXC_ADEL_D
  } exc_kind_e;

  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        tick_q;
  logic        ti_q;

  exc_kind_e   winner;
  logic [4:0]  exc_code;
  logic        exc_any;
  logic        is_eret;
  logic        take_exc;
  logic        wr_en;
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] count_next;
  logic [31:0] epc_capture;
  logic [31:0] rd_data;

  // Highest-numbered bit of the exception vector wins
  always_comb begin
    winner = EXC_NONE;
    if (bus.MEM_ExceptType[8])      winner = EXC_INT;
    else if (bus.MEM_ExceptType[7]) winner = EXC_ADEL_IF;
    else if (bus.MEM_ExceptType[6]) winner = EXC_RI;
    else if (bus.MEM_ExceptType[5]) winner = EXC_OV;
    else if (bus.MEM_ExceptType[4]) winner = EXC_SYS;
    else if (bus.MEM_ExceptType[3]) winner = EXC_BP;
    else if (bus.MEM_ExceptType[2]) winner = EXC_ERET;
    else if (bus.MEM_ExceptType[1]) winner = EXC_ADES;
    else if (bus.MEM_ExceptType[0]) winner = EXC_ADEL_D;
  end

  always_comb begin
    exc_code = 5'd0;
    case (winner)
      EXC_INT:     exc_code = 5'd0;
      EXC_ADEL_IF: exc_code = 5'd4;
      EXC_RI:      exc_code = 5'd10;
      EXC_OV:      exc_code = 5'd12;
      EXC_SYS:     exc_code = 5'd8;
      EXC_BP:      exc_code = 5'd9;
      EXC_ADES:    exc_code = 5'd5;
      EXC_ADEL_D:  exc_code = 5'd4;
      default:     exc_code = 5'd0;
    endcase
  end

  assign exc_any  = |bus.MEM_ExceptType;
  assign is_eret  = (winner == EXC_ERET);
  assign take_exc = exc_any && !is_eret;

  // Any exception or Eret in flight suppresses the MTC0 from WB
  assign wr_en      = bus.CP0_Wr && !exc_any;
  assign wr_count   = wr_en && (bus.CP0_WrAddr == REG_COUNT);
  assign wr_compare = wr_en && (bus.CP0_WrAddr == REG_COMPARE);

  assign count_next  = wr_count ? bus.CP0_WrData
                     : (tick_q ? count_q + 32'd1 : count_q);
  assign epc_capture = bus.MEM_IsDelaySlot ? bus.MEM_PC - 32'd4 : bus.MEM_PC;

  always_comb begin
    rd_data = 32'd0;
    case (bus.CP0_RdAddr)
      REG_BADVADDR: rd_data = badvaddr_q;
      REG_COUNT:    rd_data = count_q;
      REG_COMPARE:  rd_data = compare_q;
      REG_STATUS:   rd_data = status_q;
      REG_CAUSE:    rd_data = cause_q;
      REG_EPC:      rd_data = epc_q;
      default:      rd_data = 32'd0;
    endcase
  end

  assign bus.CP0_RdData  = rd_data;
  assign bus.Exc_Flush   = exc_any;
  assign bus.Exc_Target  = !exc_any ? 32'd0 : (is_eret ? epc_q : EXC_VECTOR);
  assign bus.Int_Pending = status_q[0] && !status_q[1] &&
                           |(cause_q[15:8] & status_q[15:8]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      tick_q     <= 1'b0;
      ti_q       <= 1'b0;
    end else begin
      count_q <= count_next;
      tick_q  <= wr_count ? 1'b0 : ~tick_q;

      // TI is sticky; only a Compare write clears it, and that write masks a same-cycle hit
      if (wr_compare)
        ti_q <= 1'b0;
      else if (count_next == compare_q)
        ti_q <= 1'b1;

      cause_q[15:10] <= {bus.Ext_Int[5] | ti_q, bus.Ext_Int[4:0]};

      if (take_exc) begin
        cause_q[6:2] <= exc_code;
        status_q[1]  <= 1'b1;
        if (!status_q[1]) begin
          epc_q      <= epc_capture;
          cause_q[31] <= bus.MEM_IsDelaySlot;
        end
        if (winner == EXC_ADEL_IF)
          badvaddr_q <= bus.MEM_PC;
        else if ((winner == EXC_ADES) || (winner == EXC_ADEL_D))
          badvaddr_q <= bus.MEM_ALUOut;
      end else if (is_eret) begin
        status_q[1] <= 1'b0;
      end else if (bus.CP0_Wr) begin
        case (bus.CP0_WrAddr)
          REG_COMPARE: compare_q <= bus.CP0_WrData;
          REG_STATUS:  status_q  <= (status_q & ~STATUS_WMASK) |
                                    (bus.CP0_WrData & STATUS_WMASK);
          REG_CAUSE:   cause_q[9:8] <= bus.CP0_WrData[9:8];
          REG_EPC:     epc_q <= bus.CP0_WrData;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed vector table plus hand sequences for cp0_exception_unit
module tb_cp0_exception_unit;

  localparam logic [8:0] E_INT  = 9'h100;
  localparam logic [8:0] E_IF   = 9'h080;
  localparam logic [8:0] E_RI   = 9'h040;
  localparam logic [8:0] E_OV   = 9'h020;
  localparam logic [8:0] E_SYS  = 9'h010;
  localparam logic [8:0] E_BP   = 9'h008;
  localparam logic [8:0] E_ERET = 9'h004;
  localparam logic [8:0] E_WRA  = 9'h002;
  localparam logic [8:0] E_RDA  = 9'h001;

  localparam logic [4:0] R_BADV = 5'd8;
  localparam logic [4:0] R_CNT  = 5'd9;
  localparam logic [4:0] R_CMP  = 5'd11;
  localparam logic [4:0] R_STAT = 5'd12;
  localparam logic [4:0] R_CAUS = 5'd13;
  localparam logic [4:0] R_EPC  = 5'd14;
  localparam logic [31:0] ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] VEC   = 32'hBFC0_0380;

  typedef struct {
    string       name;
    logic [8:0]  et;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        ds;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        exp_flush;
    logic [31:0] exp_target;
    logic [4:0]  ra;
    logic [31:0] rmask;
    logic [31:0] rexp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t vq[$];

  cp0_exception_unit_if bus();

  cp0_exception_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] ra,
                        input logic [31:0] mask, input logic [31:0] exp);
    bus.CP0_RdAddr = ra;
    #1;
    chk(name, bus.CP0_RdData & mask, exp);
  endtask

  task automatic idle();
    bus.MEM_ExceptType  = 9'd0;
    bus.MEM_PC          = 32'd0;
    bus.MEM_ALUOut      = 32'd0;
    bus.MEM_IsDelaySlot = 1'b0;
    bus.CP0_Wr          = 1'b0;
    bus.CP0_WrAddr      = 5'd0;
    bus.CP0_WrData      = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.CP0_Wr     = 1'b1;
    bus.CP0_WrAddr = wa;
    bus.CP0_WrData = wd;
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic vec_t mv(input string name, input logic [8:0] et,
      input logic [31:0] pc, input logic [31:0] alu, input logic ds,
      input logic wr, input logic [4:0] wa, input logic [31:0] wd,
      input logic ef, input logic [31:0] tgt,
      input logic [4:0] ra, input logic [31:0] rmask, input logic [31:0] rexp);
    vec_t v;
    v.name = name; v.et = et; v.pc = pc; v.alu = alu; v.ds = ds;
    v.wr = wr; v.wa = wa; v.wd = wd; v.exp_flush = ef; v.exp_target = tgt;
    v.ra = ra; v.rmask = rmask; v.rexp = rexp;
    return v;
  endfunction

  initial begin
    int n;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    idle();
    bus.Ext_Int    = 6'd0;
    bus.CP0_RdAddr = 5'd0;

    vq.push_back(mv("idle",        9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_STAT, ALL,          32'h0040_0000));
    vq.push_back(mv("sys_epc",     E_SYS,         32'hBFC0_0100, 32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_EPC,  ALL,          32'hBFC0_0100));
    vq.push_back(mv("sys_cause",   9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_CAUS, 32'h8000_007C, 32'h0000_0020));
    vq.push_back(mv("sys_exl",     9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_STAT, ALL,          32'h0040_0002));
    vq.push_back(mv("eret1",       E_ERET,        32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, 32'hBFC0_0100, R_STAT, ALL,          32'h0040_0000));
    vq.push_back(mv("ov_ds_epc",   E_OV | E_RDA,  32'h8000_1004, 32'h3,    1'b1, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_EPC,  ALL,          32'h8000_1000));
    vq.push_back(mv("ov_ds_cause", 9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_CAUS, 32'h8000_007C, 32'h8000_0030));
    vq.push_back(mv("ov_badv",     9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_BADV, ALL,          32'h0));
    vq.push_back(mv("eret2",       E_ERET,        32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, 32'h8000_1000, R_STAT, ALL,          32'h0040_0000));
    vq.push_back(mv("set_exl",     9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_STAT, 32'h2,        1'b0, 32'h0,         R_STAT, ALL,          32'h0040_0002));
    vq.push_back(mv("ades_epc",    E_WRA,         32'h1234_5678, 32'h1001, 1'b0, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_EPC,  ALL,          32'h8000_1000));
    vq.push_back(mv("ades_badv",   9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_BADV, ALL,          32'h0000_1001));
    vq.push_back(mv("ades_cause",  9'd0,          32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b0, 32'h0,         R_CAUS, 32'h8000_007C, 32'h8000_0014));
    vq.push_back(mv("all_int",     9'h1FF,        32'hAAAA_0000, 32'h7,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_CAUS, 32'h0000_007C, 32'h0));
    vq.push_back(mv("if_badv",     E_IF | E_RDA,  32'h0000_0013, 32'h55,   1'b0, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_BADV, ALL,          32'h0000_0013));
    vq.push_back(mv("eret_wra",    E_ERET | E_WRA,32'h0,         32'h77,   1'b0, 1'b0, 5'd0,   32'h0,        1'b1, 32'h8000_1000, R_STAT, ALL,          32'h0040_0000));
    vq.push_back(mv("ri_cause",    E_RI,          32'h8000_2000, 32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, VEC,           R_CAUS, 32'h8000_007C, 32'h0000_0028));
    vq.push_back(mv("eret3",       E_ERET,        32'h0,         32'h0,    1'b0, 1'b0, 5'd0,   32'h0,        1'b1, 32'h8000_2000, R_EPC,  ALL,          32'h8000_2000));
    vq.push_back(mv("wr_status",   9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_STAT, ALL,          1'b0, 32'h0,         R_STAT, ALL,          32'h0040_FF03));
    vq.push_back(mv("wr_cause",    9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_CAUS, ALL,          1'b0, 32'h0,         R_CAUS, 32'h0000_037C, 32'h0000_0328));
    vq.push_back(mv("wr_badv",     9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_BADV, 32'hDEAD_BEEF,1'b0, 32'h0,         R_BADV, ALL,          32'h0000_0013));
    vq.push_back(mv("wr_epc",      9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_EPC,  32'h1234_0000,1'b0, 32'h0,         R_EPC,  ALL,          32'h1234_0000));
    vq.push_back(mv("rd_unimpl",   9'd0,          32'h0,         32'h0,    1'b0, 1'b1, 5'd7,   32'h5555_5555,1'b0, 32'h0,         5'd7,   ALL,          32'h0));
    vq.push_back(mv("clr_status",  9'd0,          32'h0,         32'h0,    1'b0, 1'b1, R_STAT, 32'h0,        1'b0, 32'h0,         R_STAT, ALL,          32'h0040_0000));

    // Reset release
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_flush", {31'd0, bus.Exc_Flush}, 32'd0);
    chk("rst_target", bus.Exc_Target, 32'd0);
    chk("rst_intp", {31'd0, bus.Int_Pending}, 32'd0);
    rd_chk("rst_status", R_STAT, ALL, 32'h0040_0000);
    rd_chk("rst_cause", R_CAUS, ALL, 32'h0);
    rd_chk("rst_epc", R_EPC, ALL, 32'h0);
    rd_chk("rst_count", R_CNT, ALL, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("count_2edges", R_CNT, ALL, 32'd1);

    foreach (vq[i]) begin
      @(negedge clk);
      bus.MEM_ExceptType  = vq[i].et;
      bus.MEM_PC          = vq[i].pc;
      bus.MEM_ALUOut      = vq[i].alu;
      bus.MEM_IsDelaySlot = vq[i].ds;
      bus.CP0_Wr          = vq[i].wr;
      bus.CP0_WrAddr      = vq[i].wa;
      bus.CP0_WrData      = vq[i].wd;
      #1;
      chk({vq[i].name, "_flush"}, {31'd0, bus.Exc_Flush}, {31'd0, vq[i].exp_flush});
      chk({vq[i].name, "_target"}, bus.Exc_Target, vq[i].exp_target);
      @(posedge clk);
      #1;
      idle();
      rd_chk(vq[i].name, vq[i].ra, vq[i].rmask, vq[i].rexp);
    end

    // Count/Compare timer interrupt
    mtc0(R_CMP, 32'd5);
    mtc0(R_CNT, 32'd0);
    mtc0(R_STAT, 32'h0000_8001);
    chk("tmr_no_int_yet", {31'd0, bus.Int_Pending}, 32'd0);
    n = 0;
    while (!bus.Int_Pending && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmr_int_latency", n, 10);
    chk("tmr_int_pending", {31'd0, bus.Int_Pending}, 32'd1);
    rd_chk("tmr_ip7", R_CAUS, 32'h0000_8000, 32'h0000_8000);
    rd_chk("tmr_count", R_CNT, ALL, 32'd5);
    mtc0(R_CMP, 32'h100);
    @(posedge clk);
    #1;
    rd_chk("tmr_ip7_clr", R_CAUS, 32'h0000_8000, 32'h0);
    chk("tmr_int_clr", {31'd0, bus.Int_Pending}, 32'd0);

    // Break coincident with an MTC0 to Status: write dropped
    @(negedge clk);
    bus.MEM_ExceptType = E_BP;
    bus.MEM_PC         = 32'h8000_3000;
    bus.CP0_Wr         = 1'b1;
    bus.CP0_WrAddr     = R_STAT;
    bus.CP0_WrData     = 32'h0000_FF00;
    #1;
    chk("bp_flush", {31'd0, bus.Exc_Flush}, 32'd1);
    @(posedge clk);
    #1;
    idle();
    rd_chk("bp_status", R_STAT, ALL, 32'h0040_8003);
    rd_chk("bp_cause", R_CAUS, 32'h0000_007C, 32'h0000_0024);
    rd_chk("bp_epc", R_EPC, ALL, 32'h8000_3000);

    // Count wraps from all-ones to zero
    mtc0(R_CNT, ALL);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("count_wrap", R_CNT, ALL, 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    rd_chk("arst_status", R_STAT, ALL, 32'h0040_0000);
    rd_chk("arst_cause", R_CAUS, ALL, 32'h0);
    rd_chk("arst_epc", R_EPC, ALL, 32'h0);
    rd_chk("arst_badv", R_BADV, ALL, 32'h0);
    rd_chk("arst_compare", R_CMP, ALL, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_flush", {31'd0, bus.Exc_Flush}, 32'd0);
    rd_chk("arst_count", R_CNT, ALL, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
